// File: rtl/cfg_panel_pkg.sv
// Shared types and constants for the configuration panel controller.
// Optional feature macro used by this codebase slice: CFG_PANEL_EXT_WRITE_EN.
package cfg_panel_pkg;

   typedef enum logic [3:0] {
      S_SLAVE_SEL = 4'd0,
      S_RW_SEL    = 4'd1,
      S_EXTW_SEL  = 4'd2,
      S_EXTW_M0   = 4'd3,
      S_EXTW_M1   = 4'd4,
      S_START_M0  = 4'd5,
      S_START_M1  = 4'd6,
      S_COUNT_M0  = 4'd7,
      S_COUNT_M1  = 4'd8,
      S_CONFIG    = 4'd9,
      S_READY     = 4'd10,
      S_COMM      = 4'd11,
      S_READBACK  = 4'd12
   } state_e;

   typedef enum logic [1:0] {
      no_slave = 2'b00,
      slave_1  = 2'b01,
      slave_2  = 2'b10,
      slave_3  = 2'b11
   } slave_t;

   typedef enum logic {
      read  = 1'b0,
      write = 1'b1
   } operation_t;

   // Plain-vector state codes, kept for code that predates the enum
   localparam logic [3:0] ST_SLAVE_SEL = 4'(S_SLAVE_SEL);
   localparam logic [3:0] ST_RW_SEL    = 4'(S_RW_SEL);
   localparam logic [3:0] ST_EXTW_SEL  = 4'(S_EXTW_SEL);
   localparam logic [3:0] ST_EXTW_M0   = 4'(S_EXTW_M0);
   localparam logic [3:0] ST_EXTW_M1   = 4'(S_EXTW_M1);
   localparam logic [3:0] ST_START_M0  = 4'(S_START_M0);
   localparam logic [3:0] ST_START_M1  = 4'(S_START_M1);
   localparam logic [3:0] ST_COUNT_M0  = 4'(S_COUNT_M0);
   localparam logic [3:0] ST_COUNT_M1  = 4'(S_COUNT_M1);
   localparam logic [3:0] ST_CONFIG    = 4'(S_CONFIG);
   localparam logic [3:0] ST_READY     = 4'(S_READY);
   localparam logic [3:0] ST_COMM      = 4'(S_COMM);
   localparam logic [3:0] ST_READBACK  = 4'(S_READBACK);

   // Width of the external-write address; never below one bit
   function automatic int ext_addr_bits(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/cfg_panel_if.sv
// Configuration bus between the panel controller (master) and the two
// bus masters it configures (slave side of this interface).
// External-write signals are only active when CFG_PANEL_EXT_WRITE_EN is defined.
interface cfg_panel_if #(
   parameter int DATA_WIDTH          = 16,
   parameter int ADDR_WIDTH          = 12,
   parameter int MAX_EXT_WRITE_DEPTH = 16
);
   import cfg_panel_pkg::*;

   localparam int EXTW_AW = ext_addr_bits(MAX_EXT_WRITE_DEPTH);

   logic [1:0][1:0]            m_slave;
   logic [1:0]                 m_rw;
   logic [1:0]                 m_ext_wr;
   logic [1:0][ADDR_WIDTH-1:0] m_start_addr;
   logic [1:0][ADDR_WIDTH-1:0] m_addr_count;
   logic                       ext_wr_valid;
   logic                       ext_wr_master;
   logic [EXTW_AW-1:0]         ext_wr_addr;
   logic [DATA_WIDTH-1:0]      ext_wr_data;
   logic                       cfg_valid;
   logic                       cfg_ack;
   logic                       com_start;
   logic                       com_done;

   modport master (
      output m_slave, m_rw, m_ext_wr, m_start_addr, m_addr_count,
      output ext_wr_valid, ext_wr_master, ext_wr_addr, ext_wr_data,
      output cfg_valid, com_start,
      input  cfg_ack, com_done
   );

   modport slave (
      input  m_slave, m_rw, m_ext_wr, m_start_addr, m_addr_count,
      input  ext_wr_valid, ext_wr_master, ext_wr_addr, ext_wr_data,
      input  cfg_valid, com_start,
      output cfg_ack, com_done
   );

endinterface

// File: rtl/key_debounce.sv
// Push-button conditioner: two-flop synchroniser plus level debouncer.
// Emits a one-cycle press pulse after DEBOUNCE_CYCLES consecutive pressed
// samples, then re-arms only after DEBOUNCE_CYCLES consecutive released
// samples. Comes out of reset disarmed so a key held through reset must be
// released before it can fire.
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic key_n,
   output logic press
);
   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Synchroniser carries the pressed level (inverted key), so reset value 0 = released
   logic             pressed_s1_q, pressed_s2_q;
   logic             armed_q, armed_d;
   logic             press_q, press_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Armed: count pressed samples; disarmed: count released samples
   always_comb begin
      cnt_d   = '0;
      armed_d = armed_q;
      press_d = 1'b0;
      if (pressed_s2_q == armed_q) begin
         if (cnt_q == CNT_LAST) begin
            armed_d = ~armed_q;
            press_d = armed_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Synchroniser and debounce state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pressed_s1_q <= 1'b0;
         pressed_s2_q <= 1'b0;
         armed_q      <= 1'b0;
         press_q      <= 1'b0;
         cnt_q        <= '0;
      end else begin
         pressed_s1_q <= ~key_n;
         pressed_s2_q <= pressed_s1_q;
         armed_q      <= armed_d;
         press_q      <= press_d;
         cnt_q        <= cnt_d;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/cfg_panel_ctrl.sv
// Front-panel configuration sequencer: walks an operator through slave
// selection, read/write mode, optional external data preload, address
// windows, then hands the configuration to the masters, starts
// communication and allows readback address requests.
// Optional feature: CFG_PANEL_EXT_WRITE_EN enables the external-write
// states; without it they are bypassed and the ext_wr outputs stay 0.
module cfg_panel_ctrl
   import cfg_panel_pkg::*;
#(
   parameter int DATA_WIDTH          = 16,
   parameter int ADDR_WIDTH          = 12,
   parameter int MAX_EXT_WRITE_DEPTH = 16,
   parameter int DEBOUNCE_CYCLES     = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  jump_stateN,
   input  logic                  jump_next_addr,
   input  logic [17:0]           SW,
   cfg_panel_if.master           bus,
   output logic                  comm_ready,
   output logic                  comm_done,
   output logic                  rd_req,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [3:0]            state_o
);
   localparam int EXTW_AW = ext_addr_bits(MAX_EXT_WRITE_DEPTH);

   logic st_ev, nx_raw, nx_ev;

   logic [3:0]                 state_q, state_d;
   slave_t     [1:0]           m_slave_q, m_slave_d;
   operation_t [1:0]           m_rw_q, m_rw_d;
   logic [1:0]                 m_ext_wr_q, m_ext_wr_d;
   logic [1:0][ADDR_WIDTH-1:0] m_start_addr_q, m_start_addr_d;
   logic [1:0][ADDR_WIDTH-1:0] m_addr_count_q, m_addr_count_d;
   logic                       ext_wr_valid_q, ext_wr_valid_d;
   logic                       ext_wr_master_q, ext_wr_master_d;
   logic [EXTW_AW-1:0]         ext_wr_addr_q, ext_wr_addr_d;
   logic [DATA_WIDTH-1:0]      ext_wr_data_q, ext_wr_data_d;
   logic [EXTW_AW-1:0]         ext_cnt_q, ext_cnt_d;
   logic                       com_start_q, com_start_d;
   logic                       comm_ready_q, comm_ready_d;
   logic                       comm_done_q, comm_done_d;
   logic                       rd_req_q, rd_req_d;
   logic [ADDR_WIDTH-1:0]      rd_addr_q, rd_addr_d;
   logic                       unused_sw;

`ifdef CFG_PANEL_EXT_WRITE_EN
   localparam logic [EXTW_AW-1:0] EXT_LAST = EXTW_AW'(MAX_EXT_WRITE_DEPTH - 1);

   // Write address advances but sticks at the last location
   function automatic logic [EXTW_AW-1:0] ext_cnt_inc(input logic [EXTW_AW-1:0] cnt);
      return (cnt == EXT_LAST) ? cnt : cnt + 1'b1;
   endfunction
`endif

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_state_key (
      .clk   (clk),
      .rst   (rst),
      .key_n (jump_stateN),
      .press (st_ev)
   );

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next_key (
      .clk   (clk),
      .rst   (rst),
      .key_n (jump_next_addr),
      .press (nx_raw)
   );

   // A simultaneous state event wins; the next-address event is dropped
   assign nx_ev = nx_raw & ~st_ev;

   // Sequencer next-state and field latching
   always_comb begin
      state_d         = state_q;
      m_slave_d       = m_slave_q;
      m_rw_d          = m_rw_q;
      m_ext_wr_d      = m_ext_wr_q;
      m_start_addr_d  = m_start_addr_q;
      m_addr_count_d  = m_addr_count_q;
      ext_wr_valid_d  = 1'b0;
      ext_wr_master_d = ext_wr_master_q;
      ext_wr_addr_d   = ext_wr_addr_q;
      ext_wr_data_d   = ext_wr_data_q;
      ext_cnt_d       = ext_cnt_q;
      com_start_d     = 1'b0;
      comm_ready_d    = comm_ready_q;
      comm_done_d     = comm_done_q;
      rd_req_d        = 1'b0;
      rd_addr_d       = rd_addr_q;

      case (state_q)
         ST_SLAVE_SEL: if (st_ev) begin
            m_slave_d[0] = slave_t'(SW[1:0]);
            m_slave_d[1] = slave_t'(SW[3:2]);
            state_d      = ST_RW_SEL;
         end
         ST_RW_SEL: if (st_ev) begin
            m_rw_d[0] = operation_t'(SW[0]);
            m_rw_d[1] = operation_t'(SW[1]);
`ifdef CFG_PANEL_EXT_WRITE_EN
            state_d   = ST_EXTW_SEL;
`else
            state_d   = ST_START_M0;
`endif
         end
`ifdef CFG_PANEL_EXT_WRITE_EN
         ST_EXTW_SEL: if (st_ev) begin
            m_ext_wr_d = SW[1:0];
            ext_cnt_d  = '0;
            if (SW[0])      state_d = ST_EXTW_M0;
            else if (SW[1]) state_d = ST_EXTW_M1;
            else            state_d = ST_START_M0;
         end
         ST_EXTW_M0, ST_EXTW_M1: if (st_ev || nx_ev) begin
            // Every key event stores the current word; only next-address advances
            ext_wr_valid_d  = 1'b1;
            ext_wr_master_d = (state_q == ST_EXTW_M1);
            ext_wr_addr_d   = ext_cnt_q;
            ext_wr_data_d   = SW[DATA_WIDTH-1:0];
            if (nx_ev) begin
               ext_cnt_d = ext_cnt_inc(ext_cnt_q);
            end else begin
               ext_cnt_d = '0;
               if (state_q == ST_EXTW_M0 && m_ext_wr_q[1]) state_d = ST_EXTW_M1;
               else                                        state_d = ST_START_M0;
            end
         end
`else
         ST_EXTW_SEL, ST_EXTW_M0, ST_EXTW_M1: state_d = ST_START_M0;
`endif
         ST_START_M0: if (st_ev) begin
            m_start_addr_d[0] = SW[ADDR_WIDTH-1:0];
            state_d           = ST_START_M1;
         end
         ST_START_M1: if (st_ev) begin
            m_start_addr_d[1] = SW[ADDR_WIDTH-1:0];
            state_d           = ST_COUNT_M0;
         end
         ST_COUNT_M0: if (st_ev) begin
            m_addr_count_d[0] = SW[ADDR_WIDTH-1:0];
            state_d           = ST_COUNT_M1;
         end
         ST_COUNT_M1: if (st_ev) begin
            m_addr_count_d[1] = SW[ADDR_WIDTH-1:0];
            state_d           = ST_CONFIG;
         end
         ST_CONFIG: if (bus.cfg_ack) begin
            comm_ready_d = 1'b1;
            state_d      = ST_READY;
         end
         ST_READY: if (st_ev) begin
            com_start_d = 1'b1;
            state_d     = ST_COMM;
         end
         ST_COMM: if (bus.com_done) begin
            comm_done_d = 1'b1;
            state_d     = ST_READBACK;
         end
         ST_READBACK: begin
            if (st_ev) begin
               comm_ready_d = 1'b0;
               comm_done_d  = 1'b0;
               state_d      = ST_SLAVE_SEL;
            end else if (nx_ev) begin
               rd_addr_d = SW[ADDR_WIDTH-1:0];
               rd_req_d  = 1'b1;
            end
         end
         default: state_d = ST_SLAVE_SEL;
      endcase
   end

   // Sequencer registers; reset clears every field and output
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= ST_SLAVE_SEL;
         m_slave_q[0]    <= no_slave;
         m_slave_q[1]    <= no_slave;
         m_rw_q[0]       <= read;
         m_rw_q[1]       <= read;
         m_ext_wr_q      <= '0;
         m_start_addr_q  <= '0;
         m_addr_count_q  <= '0;
         ext_wr_valid_q  <= 1'b0;
         ext_wr_master_q <= 1'b0;
         ext_wr_addr_q   <= '0;
         ext_wr_data_q   <= '0;
         ext_cnt_q       <= '0;
         com_start_q     <= 1'b0;
         comm_ready_q    <= 1'b0;
         comm_done_q     <= 1'b0;
         rd_req_q        <= 1'b0;
         rd_addr_q       <= '0;
      end else begin
         state_q         <= state_d;
         m_slave_q       <= m_slave_d;
         m_rw_q          <= m_rw_d;
         m_ext_wr_q      <= m_ext_wr_d;
         m_start_addr_q  <= m_start_addr_d;
         m_addr_count_q  <= m_addr_count_d;
         ext_wr_valid_q  <= ext_wr_valid_d;
         ext_wr_master_q <= ext_wr_master_d;
         ext_wr_addr_q   <= ext_wr_addr_d;
         ext_wr_data_q   <= ext_wr_data_d;
         ext_cnt_q       <= ext_cnt_d;
         com_start_q     <= com_start_d;
         comm_ready_q    <= comm_ready_d;
         comm_done_q     <= comm_done_d;
         rd_req_q        <= rd_req_d;
         rd_addr_q       <= rd_addr_d;
      end
   end

   assign bus.m_slave       = m_slave_q;
   assign bus.m_rw          = m_rw_q;
   assign bus.m_ext_wr      = m_ext_wr_q;
   assign bus.m_start_addr  = m_start_addr_q;
   assign bus.m_addr_count  = m_addr_count_q;
   assign bus.ext_wr_valid  = ext_wr_valid_q;
   assign bus.ext_wr_master = ext_wr_master_q;
   assign bus.ext_wr_addr   = ext_wr_addr_q;
   assign bus.ext_wr_data   = ext_wr_data_q;
   assign bus.cfg_valid     = (state_q == ST_CONFIG);
   assign bus.com_start     = com_start_q;
   assign comm_ready        = comm_ready_q;
   assign comm_done         = comm_done_q;
   assign rd_req            = rd_req_q;
   assign rd_addr           = rd_addr_q;
   assign state_o           = state_q;

   // Not every switch bit feeds a field in every build
   assign unused_sw = ^SW;

endmodule

// File: tb/tb_cfg_panel_ctrl.sv
// Directed bench for cfg_panel_ctrl with a scoreboard for the strobed
// outputs (external writes and readback requests).
// Build with CFG_PANEL_EXT_WRITE_EN defined to also exercise external writes.
`timescale 1ns/1ps
module tb_cfg_panel_ctrl;
   import cfg_panel_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        jump_stateN = 1'b1;
   logic        jump_next_addr = 1'b1;
   logic [17:0] SW = '0;
   logic        comm_ready, comm_done, rd_req;
   logic [11:0] rd_addr;
   logic [3:0]  state_o;

   int n_assert = 0;
   int n_fail = 0;
   int n_com_start = 0;

   logic [31:0] ext_q[$];
   logic [11:0] rd_q[$];

   cfg_panel_if bus_if ();

   cfg_panel_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .jump_stateN    (jump_stateN),
      .jump_next_addr (jump_next_addr),
      .SW             (SW),
      .bus            (bus_if),
      .comm_ready     (comm_ready),
      .comm_done      (comm_done),
      .rd_req         (rd_req),
      .rd_addr        (rd_addr),
      .state_o        (state_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press_state();
      jump_stateN = 1'b0;
      tick(10);
      jump_stateN = 1'b1;
      tick(12);
   endtask

   task automatic press_next();
      jump_next_addr = 1'b0;
      tick(10);
      jump_next_addr = 1'b1;
      tick(12);
   endtask

   task automatic press_both();
      jump_stateN    = 1'b0;
      jump_next_addr = 1'b0;
      tick(10);
      jump_stateN    = 1'b1;
      jump_next_addr = 1'b1;
      tick(12);
   endtask

   // Scoreboard: compare strobed outputs against queued expectations
   always @(negedge clk) begin
      if (!rst) begin
         if (bus_if.ext_wr_valid) begin
            if (ext_q.size() == 0)
               check("ext_wr_unexpected",
                     {11'd0, bus_if.ext_wr_master, bus_if.ext_wr_addr, bus_if.ext_wr_data},
                     32'hFFFF_FFFF);
            else
               check("ext_wr",
                     {11'd0, bus_if.ext_wr_master, bus_if.ext_wr_addr, bus_if.ext_wr_data},
                     ext_q.pop_front());
         end
         if (rd_req) begin
            if (rd_q.size() == 0)
               check("rd_req_unexpected", 32'(rd_addr), 32'hFFFF_FFFF);
            else
               check("rd_addr", 32'(rd_addr), 32'(rd_q.pop_front()));
         end
         if (bus_if.com_start) n_com_start++;
      end
   end

   // Watchdog so the run always ends
   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus_if.cfg_ack  = 1'b0;
      bus_if.com_done = 1'b0;
      tick(2);

      // Reset state
      check("rst_state", 32'(state_o), 32'(ST_SLAVE_SEL));
      check("rst_m_slave", 32'(bus_if.m_slave), 32'd0);
      check("rst_cfg_valid", 32'(bus_if.cfg_valid), 32'd0);
      check("rst_comm_ready", 32'(comm_ready), 32'd0);
      rst = 1'b0;
      tick(8);

      // Slave select with event latency check
      SW = 18'h9;
      jump_stateN = 1'b0;
      tick(5);
      check("pre_event_state", 32'(state_o), 32'(ST_SLAVE_SEL));
      tick(3);
      check("slave_sel_state", 32'(state_o), 32'(ST_RW_SEL));
      tick(2);
      jump_stateN = 1'b1;
      tick(12);
      check("m_slave0", 32'(bus_if.m_slave[0]), 32'h1);
      check("m_slave1", 32'(bus_if.m_slave[1]), 32'h2);

      // Next-address key ignored in RW_SEL
      press_next();
      check("next_ignored_rw", 32'(state_o), 32'(ST_RW_SEL));

      SW = 18'h1;
      press_state();
      check("m_rw", 32'(bus_if.m_rw), 32'h1);
`ifdef CFG_PANEL_EXT_WRITE_EN
      check("extw_sel_state", 32'(state_o), 32'(ST_EXTW_SEL));
      SW = 18'h1;
      press_state();
      check("m_ext_wr", 32'(bus_if.m_ext_wr), 32'h1);
      check("extw_m0_state", 32'(state_o), 32'(ST_EXTW_M0));
      for (int i = 0; i < 9; i++) begin
         SW = 18'(16'hA000 + i);
         ext_q.push_back({11'd0, 1'b0, 4'(i), 16'(16'hA000 + i)});
         press_next();
      end
      SW = 18'h0A009;
      ext_q.push_back({11'd0, 1'b0, 4'd9, 16'hA009});
      press_state();
      check("m1_skipped", 32'(state_o), 32'(ST_START_M0));
      check("ext_last_addr", 32'(bus_if.ext_wr_addr), 32'd9);
      check("ext_q_empty_1", 32'(ext_q.size()), 32'd0);
`else
      check("rw_to_start", 32'(state_o), 32'(ST_START_M0));
      check("m_ext_wr_tied", 32'(bus_if.m_ext_wr), 32'd0);
`endif

      // Address windows, auto entry into CONFIG
      SW = 18'h123; press_state();
      check("m_start0", 32'(bus_if.m_start_addr[0]), 32'h123);
      SW = 18'h456; press_state();
      check("m_start1", 32'(bus_if.m_start_addr[1]), 32'h456);
      SW = 18'h010; press_state();
      check("m_count0", 32'(bus_if.m_addr_count[0]), 32'h010);
      SW = 18'h020; press_state();
      check("m_count1", 32'(bus_if.m_addr_count[1]), 32'h020);
      check("config_state", 32'(state_o), 32'(ST_CONFIG));
      check("cfg_valid", 32'(bus_if.cfg_valid), 32'd1);

      // Keys ignored in CONFIG
      press_state();
      check("config_key_ignored", 32'(state_o), 32'(ST_CONFIG));

      tick(5);
      bus_if.cfg_ack = 1'b1;
      tick(1);
      bus_if.cfg_ack = 1'b0;
      check("ready_state", 32'(state_o), 32'(ST_READY));
      check("comm_ready_set", 32'(comm_ready), 32'd1);
      check("cfg_valid_off", 32'(bus_if.cfg_valid), 32'd0);

      // Start communication: exactly one pulse
      n_com_start = 0;
      press_state();
      check("com_start_once", 32'(n_com_start), 32'd1);
      check("comm_state", 32'(state_o), 32'(ST_COMM));
      press_state();
      check("comm_key_ignored", 32'(state_o), 32'(ST_COMM));
      check("com_start_still_once", 32'(n_com_start), 32'd1);

      bus_if.com_done = 1'b1;
      tick(1);
      bus_if.com_done = 1'b0;
      check("readback_state", 32'(state_o), 32'(ST_READBACK));
      check("comm_done_set", 32'(comm_done), 32'd1);

      // Readback requests
      SW = 18'hABC; rd_q.push_back(12'hABC); press_next();
      check("rd_addr_1", 32'(rd_addr), 32'hABC);
      SW = 18'h5A5; rd_q.push_back(12'h5A5); press_next();
      check("rd_q_empty", 32'(rd_q.size()), 32'd0);

      press_state();
      check("back_to_slave_sel", 32'(state_o), 32'(ST_SLAVE_SEL));
      check("comm_ready_clr", 32'(comm_ready), 32'd0);
      check("comm_done_clr", 32'(comm_done), 32'd0);

      // Second pass with non-zero fields, then reset during COMM
      SW = 18'h6; press_state();
      SW = 18'h3; press_state();
`ifdef CFG_PANEL_EXT_WRITE_EN
      SW = 18'h3; press_state();
      check("extw_m0_state_2", 32'(state_o), 32'(ST_EXTW_M0));
      for (int i = 0; i < 20; i++) begin
         SW = 18'(16'h5000 + i);
         ext_q.push_back({11'd0, 1'b0, (i < 15) ? 4'(i) : 4'd15, 16'(16'h5000 + i)});
         press_next();
      end
      check("ext_addr_saturated", 32'(bus_if.ext_wr_addr), 32'd15);
      SW = 18'h7777;
      ext_q.push_back({11'd0, 1'b0, 4'd15, 16'h7777});
      press_both();
      check("both_keys_state", 32'(state_o), 32'(ST_EXTW_M1));
      SW = 18'h8888;
      ext_q.push_back({11'd0, 1'b1, 4'd0, 16'h8888});
      press_state();
      check("ext_q_empty_2", 32'(ext_q.size()), 32'd0);
`endif
      check("start_m0_state_2", 32'(state_o), 32'(ST_START_M0));
      SW = 18'h0F1; press_state();
      SW = 18'h0F2; press_state();
      SW = 18'h0F3; press_state();
      SW = 18'h0F4; press_state();
      bus_if.cfg_ack = 1'b1;
      tick(1);
      bus_if.cfg_ack = 1'b0;
      press_state();
      check("comm_state_2", 32'(state_o), 32'(ST_COMM));
      tick(3);

      rst = 1'b1;
      #1;
      check("rst_comm_state", 32'(state_o), 32'(ST_SLAVE_SEL));
      check("rst_comm_ready", 32'(comm_ready), 32'd0);
      check("rst_m_slave_2", 32'(bus_if.m_slave), 32'd0);
      check("rst_m_rw", 32'(bus_if.m_rw), 32'd0);
      check("rst_start", 32'(bus_if.m_start_addr), 32'd0);
      check("rst_count", 32'(bus_if.m_addr_count), 32'd0);
      check("rst_rd_addr", 32'(rd_addr), 32'd0);
      check("rst_ext", {bus_if.m_ext_wr, bus_if.ext_wr_valid, bus_if.ext_wr_master,
                        bus_if.ext_wr_addr, bus_if.ext_wr_data}, 32'd0);
      check("rst_strobes", {29'd0, bus_if.com_start, rd_req, bus_if.cfg_valid}, 32'd0);

      // Key held low through reset must not fire until released
      jump_stateN = 1'b0;
      tick(3);
      rst = 1'b0;
      tick(20);
      check("held_key_no_event", 32'(state_o), 32'(ST_SLAVE_SEL));
      jump_stateN = 1'b1;
      tick(12);
      SW = 18'h0;
      press_state();
      check("press_after_release", 32'(state_o), 32'(ST_RW_SEL));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
